// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared types and constants for the ANN neuron sequencer
// Optional feature macro: ANN_NEURON_SEQ_BIAS_EN (one bias term appended per neuron).
// Contents: data width, Q4.28 unity constant, bias term count, FSM state encoding.
package ann_pkg;

    localparam int DW = 32;
    localparam logic [DW-1:0] ONE_Q28 = 32'h1000_0000;

`ifdef ANN_NEURON_SEQ_BIAS_EN
    localparam int BIAS_TERMS = 1;
`else
    localparam int BIAS_TERMS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/ann_neuron_seq_if.sv
// rtl/ann_neuron_seq_if.sv - control, buffer and MAC signals of the neuron sequencer
// master: the sequencer (drives oX, samples iX); slave: buffers/MAC/controller side.
// Signals: iStart/oBusy/oDone control, oIn_addr/iIn_data input RAM, oW_addr/iW_data
// weight ROM, oMac_* / iMac_result MAC unit, oOut_we/oOut_addr/oOut_data output buffer.
interface ann_neuron_seq_if #(
    parameter int AW_IN  = 9,
    parameter int AW_W   = 14,
    parameter int AW_OUT = 5
);

    logic                   iStart;
    logic                   oBusy;
    logic                   oDone;
    logic [AW_IN-1:0]       oIn_addr;
    logic [ann_pkg::DW-1:0] iIn_data;
    logic [AW_W-1:0]        oW_addr;
    logic [ann_pkg::DW-1:0] iW_data;
    logic                   oMac_input_ready;
    logic                   oMac_finish;
    logic [ann_pkg::DW-1:0] oMac_data;
    logic [ann_pkg::DW-1:0] oMac_weight;
    logic [ann_pkg::DW-1:0] iMac_result;
    logic                   oOut_we;
    logic [AW_OUT-1:0]      oOut_addr;
    logic [ann_pkg::DW-1:0] oOut_data;

    modport master (
        input  iStart, iIn_data, iW_data, iMac_result,
        output oBusy, oDone, oIn_addr, oW_addr, oMac_input_ready, oMac_finish,
               oMac_data, oMac_weight, oOut_we, oOut_addr, oOut_data
    );

    modport slave (
        output iStart, iIn_data, iW_data, iMac_result,
        input  oBusy, oDone, oIn_addr, oW_addr, oMac_input_ready, oMac_finish,
               oMac_data, oMac_weight, oOut_we, oOut_addr, oOut_data
    );

endinterface

// File: rtl/ann_addr_gen.sv
// rtl/ann_addr_gen.sv - term/neuron counters and running weight address for the sequencer
// Optional feature macro: ANN_NEURON_SEQ_BIAS_EN (via ann_pkg::BIAS_TERMS).
// Ports: iClk, iReset_n; clear (hold all at 0), step (advance one term),
// next_neuron (k=0, n++); in_addr, w_addr, neuron, last_term, last_neuron, bias_term.
module ann_addr_gen
    import ann_pkg::*;
#(
    parameter int N_IN     = 400,
    parameter int N_NEURON = 25,
    parameter int AW_IN    = 9,
    parameter int AW_W     = 14,
    parameter int AW_OUT   = 5
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              clear,
    input  logic              step,
    input  logic              next_neuron,
    output logic [AW_IN-1:0]  in_addr,
    output logic [AW_W-1:0]   w_addr,
    output logic [AW_OUT-1:0] neuron,
    output logic              last_term,
    output logic              last_neuron,
    output logic              bias_term
);

    localparam int N_TERM = N_IN + BIAS_TERMS;
    // One spare bit so the bias index k == N_IN fits even when N_IN == 2^AW_IN.
    localparam int KW = AW_IN + 1;
    localparam logic [KW-1:0]     K_LAST    = KW'(N_TERM - 1);
    localparam logic [KW-1:0]     K_BIAS    = KW'(N_IN);
    localparam logic [AW_OUT-1:0] N_LAST    = AW_OUT'(N_NEURON - 1);
    localparam logic [AW_W-1:0]   BIAS_BASE = AW_W'(N_IN * N_NEURON);

    logic [KW-1:0]     k;
    logic [AW_OUT-1:0] n;
    logic [AW_W-1:0]   w_run;

    assign last_term   = (k == K_LAST);
    assign last_neuron = (n == N_LAST);
    assign bias_term   = (BIAS_TERMS != 0) && (k == K_BIAS);
    assign in_addr     = k[AW_IN-1:0];
    assign neuron      = n;
    // Bias weights live after the full weight matrix, one per neuron.
    assign w_addr      = bias_term ? (BIAS_BASE + AW_W'(n)) : w_run;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            k     <= '0;
            n     <= '0;
            w_run <= '0;
        end else if (clear) begin
            k     <= '0;
            n     <= '0;
            w_run <= '0;
        end else if (next_neuron) begin
            k <= '0;
            n <= n + AW_OUT'(1);
        end else if (step) begin
            if (!last_term) begin
                k <= k + KW'(1);
            end
            // Rows are contiguous, so stepping past the last data term of row n
            // lands exactly on row n+1; the bias term does not consume a slot.
            if (!bias_term) begin
                w_run <= w_run + AW_W'(1);
            end
        end
    end

endmodule

// File: rtl/ann_neuron_seq.sv
// rtl/ann_neuron_seq.sv - time-multiplexes one MAC over all neurons of an ANN layer
// Optional feature macro: ANN_NEURON_SEQ_BIAS_EN (adds a 1.0 x bias term per neuron).
// Ports: iClk, iReset_n (async, active low); bus (ann_neuron_seq_if.master) carrying
// start/busy/done, input RAM and weight ROM reads, MAC drive/result and output writes.
module ann_neuron_seq
    import ann_pkg::*;
#(
    parameter int N_IN     = 400,
    parameter int N_NEURON = 25,
    parameter int MAC_LAT  = 3,
    parameter int AW_IN    = 9,
    parameter int AW_W     = 14,
    parameter int AW_OUT   = 5
) (
    input  logic iClk,
    input  logic iReset_n,
    ann_neuron_seq_if.master bus
);

    localparam int CW = $clog2(MAC_LAT + 2);
    // DRAIN covers the trailing RAM-latency cycle plus MAC_LAT pipeline cycles.
    localparam logic [CW-1:0] DRAIN_LAST = CW'(MAC_LAT);

    state_t            state;
    logic              busy;
    logic              done;
    logic              mac_rdy;
    logic              bias_d;
    logic              out_we;
    logic [AW_OUT-1:0] out_addr;
    logic [CW-1:0]     drain_cnt;

    logic [AW_IN-1:0]  in_addr;
    logic [AW_W-1:0]   w_addr;
    logic [AW_OUT-1:0] neuron;
    logic              last_term;
    logic              last_neuron;
    logic              bias_term;

    ann_addr_gen #(
        .N_IN     (N_IN),
        .N_NEURON (N_NEURON),
        .AW_IN    (AW_IN),
        .AW_W     (AW_W),
        .AW_OUT   (AW_OUT)
    ) u_addr_gen (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .clear       (state == IDLE),
        .step        (state == STREAM),
        .next_neuron ((state == WRITE) && !last_neuron),
        .in_addr     (in_addr),
        .w_addr      (w_addr),
        .neuron      (neuron),
        .last_term   (last_term),
        .last_neuron (last_neuron),
        .bias_term   (bias_term)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_rdy   <= 1'b0;
            bias_d    <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            drain_cnt <= '0;
        end else begin
            mac_rdy <= 1'b0;
            bias_d  <= 1'b0;
            out_we  <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    // The address issued now returns data next cycle; present it then.
                    mac_rdy <= 1'b1;
                    bias_d  <= bias_term;
                    if (last_term) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= WRITE;
                        out_we   <= 1'b1;
                        out_addr <= neuron;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                WRITE: begin
                    if (last_neuron) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= STREAM;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oBusy            = busy;
    assign bus.oDone            = done;
    assign bus.oIn_addr         = in_addr;
    assign bus.oW_addr          = w_addr;
    assign bus.oMac_input_ready = mac_rdy;
    // Finish clears the MAC accumulator in the same cycle its result is stored.
    assign bus.oMac_finish      = out_we;
    assign bus.oMac_data        = mac_rdy ? (bias_d ? ONE_Q28 : bus.iIn_data) : '0;
    assign bus.oMac_weight      = mac_rdy ? bus.iW_data : '0;
    assign bus.oOut_we          = out_we;
    assign bus.oOut_addr        = out_addr;
    assign bus.oOut_data        = out_we ? bus.iMac_result : '0;

endmodule
